// File: rtl/svreal_rec_pkg.sv
`default_nettype none
// ============================================================================
// Package     : svreal_rec_pkg
// Description : Shared types and helpers for HardFloat recoded (recFN) blocks.
//               Holds the value class enum, the recoded word width helper and
//               the exponent-tag patterns used to classify a recFN word.
// Revision    : 1.0 - initial release
// ============================================================================
package svreal_rec_pkg;

    // Value class of a recFN word
    typedef enum logic [1:0] {
        REC_ZERO   = 2'd0,
        REC_FINITE = 2'd1,
        REC_INF    = 2'd2,
        REC_NAN    = 2'd3
    } rec_class_t;

    // Top three bits of the recoded exponent select the class; every other
    // pattern is a finite nonzero value.
    localparam logic [2:0] c_TAG_ZERO = 3'b000;
    localparam logic [2:0] c_TAG_INF  = 3'b110;
    localparam logic [2:0] c_TAG_NAN  = 3'b111;

    // Recoded word: sign + (exp_bits+1)-bit exponent + (sig_bits-1)-bit fraction
    function automatic int rec_width(input int exp_bits, input int sig_bits);
        return exp_bits + sig_bits + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rec_fn_classify.sv
`default_nettype none
// ============================================================================
// Module      : rec_fn_classify
// Description : Combinational decode of a recFN word into class, sign,
//               unbiased exponent and integer significand {1, frac}.
//               Subnormals arrive already normalised by the recoding, so the
//               hidden bit is always 1 for finite nonzero values.
// Ports       : i_rec   - recFN word (sign, exponent, fraction)
//               o_cls   - value class
//               o_sign  - sign bit
//               o_exp   - E = expField - 2^EXP_BITS (signed)
//               o_sig   - M = {1, frac}
// Revision    : 1.0 - initial release
// ============================================================================
module rec_fn_classify
    import svreal_rec_pkg::*;
#(
    parameter  int EXP_BITS = 8,
    parameter  int SIG_BITS = 24,
    localparam int REC_W    = rec_width(EXP_BITS, SIG_BITS)
) (
    input  logic [REC_W-1:0]           i_rec,
    output rec_class_t                 o_cls,
    output logic                       o_sign,
    output logic signed [EXP_BITS+1:0] o_exp,
    output logic [SIG_BITS-1:0]        o_sig
);

    logic [EXP_BITS:0] w_exp_field;
    logic [2:0]        w_tag;

    assign w_exp_field = i_rec[REC_W-2 -: EXP_BITS+1];
    assign w_tag       = w_exp_field[EXP_BITS -: 3];

    always_comb begin
        o_cls = REC_FINITE;
        case (w_tag)
            c_TAG_ZERO: o_cls = REC_ZERO;
            c_TAG_INF:  o_cls = REC_INF;
            c_TAG_NAN:  o_cls = REC_NAN;
            default:    o_cls = REC_FINITE;
        endcase
    end

    assign o_sign = i_rec[REC_W-1];

    // The recoded exponent is biased by exactly 2^EXP_BITS
    assign o_exp = $signed({1'b0, w_exp_field}) - $signed({2'b01, {EXP_BITS{1'b0}}});

    assign o_sig = {1'b1, i_rec[SIG_BITS-2:0]};

endmodule
`default_nettype wire

// File: rtl/rec_to_fixed_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rec_to_fixed_pipe
// Description : Three-stage valid/ready converter from recFN to signed fixed
//               point (real value = out_data * 2^FIX_EXP). Stage 1 decodes,
//               stage 2 aligns the significand, stage 3 rounds and saturates.
//               Zero, tiny, huge, inf and nan are handled explicitly.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               in_valid/in_ready   - input handshake
//               in_data             - recFN word
//               out_valid/out_ready - output handshake
//               out_data            - signed fixed-point result
//               out_ovf             - result saturated (overflow or inf)
//               out_nan             - input was nan, out_data is 0
//               out_udf             - nonzero finite input rounded to 0
// Revision    : 1.0 - initial release
// ============================================================================
module rec_to_fixed_pipe
    import svreal_rec_pkg::*;
#(
    parameter  int EXP_BITS  = 8,
    parameter  int SIG_BITS  = 24,
    parameter  int FIX_WIDTH = 25,
    parameter  int FIX_EXP   = -16,
    parameter  int ROUND     = 1,
    localparam int REC_W     = rec_width(EXP_BITS, SIG_BITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REC_W-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FIX_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    output logic                 out_nan,
    output logic                 out_udf
);

    // Fraction bits kept below the output LSB while aligning: enough that a
    // right shift by SIG_BITS+1 still lands every significand bit in
    // guard/sticky.
    localparam int c_FB  = SIG_BITS + 1;
    // Alignment buffer: significand shifted left by up to c_FB+FIX_WIDTH-1
    localparam int c_VW  = SIG_BITS + c_FB + FIX_WIDTH;
    localparam int c_SHW = $clog2(c_VW);

    // Magnitude bounds (FIX_WIDTH+2 bits so the rounding carry is visible)
    localparam logic [FIX_WIDTH+1:0] c_POS_MAG = {3'b000, {(FIX_WIDTH-1){1'b1}}};
    localparam logic [FIX_WIDTH+1:0] c_NEG_MAG = {3'b001, {(FIX_WIDTH-1){1'b0}}};
    localparam logic [FIX_WIDTH-1:0] c_POS_LIM = {1'b0, {(FIX_WIDTH-1){1'b1}}};
    localparam logic [FIX_WIDTH-1:0] c_NEG_LIM = {1'b1, {(FIX_WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Handshake: a stage loads when empty or when its content moves on.
    // The ready path is combinational from out_ready back to in_ready so
    // a single bubble anywhere lets upstream advance during a stall.
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic r_v3;
    logic w_ld1;
    logic w_ld2;
    logic w_ld3;

    assign w_ld3     = !r_v3 || out_ready;
    assign w_ld2     = !r_v2 || w_ld3;
    assign w_ld1     = !r_v1 || w_ld2;
    assign in_ready  = rst_n && w_ld1;
    assign out_valid = r_v3;

    // ------------------------------------------------------------------
    // Stage 1: decode
    // ------------------------------------------------------------------
    rec_class_t                 w_dec_cls;
    logic                       w_dec_sign;
    logic signed [EXP_BITS+1:0] w_dec_exp;
    logic [SIG_BITS-1:0]        w_dec_sig;

    rec_fn_classify #(
        .EXP_BITS (EXP_BITS),
        .SIG_BITS (SIG_BITS)
    ) u_classify (
        .i_rec  (in_data),
        .o_cls  (w_dec_cls),
        .o_sign (w_dec_sign),
        .o_exp  (w_dec_exp),
        .o_sig  (w_dec_sig)
    );

    rec_class_t                 r_s1_cls;
    logic                       r_s1_sign;
    logic signed [EXP_BITS+1:0] r_s1_exp;
    logic [SIG_BITS-1:0]        r_s1_sig;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_s1_cls  <= REC_ZERO;
            r_s1_sign <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_sig  <= '0;
        end else if (w_ld1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1_cls  <= w_dec_cls;
                r_s1_sign <= w_dec_sign;
                r_s1_exp  <= w_dec_exp;
                r_s1_sig  <= w_dec_sig;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: align. S is the left shift that maps M (an integer with
    // SIG_BITS-1 fraction bits) onto the output LSB weight 2^FIX_EXP.
    // ------------------------------------------------------------------
    logic signed [31:0]   w_shift;
    logic [c_SHW-1:0]     w_sh;
    logic [c_VW-1:0]      w_wide;
    logic [FIX_WIDTH:0]   w_mag;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_big;

    assign w_shift = $signed({{(32-EXP_BITS-2){r_s1_exp[EXP_BITS+1]}}, r_s1_exp})
                     - (SIG_BITS - 1) - FIX_EXP;
    // Only meaningful while -c_FB <= S < FIX_WIDTH; other ranges are
    // overridden below.
    assign w_sh    = c_SHW'(w_shift + c_FB);
    assign w_wide  = {{(c_VW-SIG_BITS){1'b0}}, r_s1_sig} << w_sh;

    always_comb begin
        w_mag    = w_wide[c_FB +: FIX_WIDTH+1];
        w_guard  = w_wide[c_FB-1];
        w_sticky = |w_wide[c_FB-2:0];
        // Definitely too large: shift past the output, or bits pushed out
        // above the FIX_WIDTH+1-bit magnitude.
        w_big    = (w_shift >= FIX_WIDTH) || (|w_wide[c_VW-1:c_FB+FIX_WIDTH+1]);
        if (w_shift < -c_FB) begin
            w_mag    = '0;
            w_guard  = 1'b0;
            w_sticky = 1'b1;
            w_big    = 1'b0;
        end
    end

    rec_class_t         r_s2_cls;
    logic               r_s2_sign;
    logic [FIX_WIDTH:0] r_s2_mag;
    logic               r_s2_guard;
    logic               r_s2_sticky;
    logic               r_s2_big;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v2        <= 1'b0;
            r_s2_cls    <= REC_ZERO;
            r_s2_sign   <= 1'b0;
            r_s2_mag    <= '0;
            r_s2_guard  <= 1'b0;
            r_s2_sticky <= 1'b0;
            r_s2_big    <= 1'b0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_cls    <= r_s1_cls;
                r_s2_sign   <= r_s1_sign;
                r_s2_mag    <= w_mag;
                r_s2_guard  <= w_guard;
                r_s2_sticky <= w_sticky;
                r_s2_big    <= w_big;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round and saturate
    // ------------------------------------------------------------------
    logic w_inc;

    if (ROUND != 0) begin : g_round_nearest
        // Adding the guard bit to the magnitude gives ties away from zero
        assign w_inc = r_s2_guard;
    end else begin : g_round_trunc
        assign w_inc = 1'b0;
    end

    logic [FIX_WIDTH+1:0] w_rnd;
    logic [FIX_WIDTH-1:0] w_data;
    logic                 w_ovf;
    logic                 w_nan;
    logic                 w_udf;

    assign w_rnd = {1'b0, r_s2_mag} + (FIX_WIDTH+2)'(w_inc);

    always_comb begin
        w_data = '0;
        w_ovf  = 1'b0;
        w_nan  = 1'b0;
        w_udf  = 1'b0;
        case (r_s2_cls)
            REC_INF: begin
                w_data = r_s2_sign ? c_NEG_LIM : c_POS_LIM;
                w_ovf  = 1'b1;
            end
            REC_NAN: begin
                w_nan = 1'b1;
            end
            REC_FINITE: begin
                if (r_s2_sign) begin
                    // -2^(FIX_WIDTH-1) is representable, so the negative
                    // bound is one larger than the positive one.
                    if (r_s2_big || (w_rnd > c_NEG_MAG)) begin
                        w_data = c_NEG_LIM;
                        w_ovf  = 1'b1;
                    end else begin
                        w_data = -w_rnd[FIX_WIDTH-1:0];
                    end
                end else begin
                    if (r_s2_big || (w_rnd > c_POS_MAG)) begin
                        w_data = c_POS_LIM;
                        w_ovf  = 1'b1;
                    end else begin
                        w_data = w_rnd[FIX_WIDTH-1:0];
                    end
                end
                // A finite value is never exactly zero before rounding, so
                // mag/guard/sticky always hold at least one set bit here.
                w_udf = !w_ovf && (w_rnd == '0) &&
                        ((|r_s2_mag) || r_s2_guard || r_s2_sticky);
            end
            default: begin
                w_data = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v3     <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
            out_nan  <= 1'b0;
            out_udf  <= 1'b0;
        end else if (w_ld3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                out_data <= w_data;
                out_ovf  <= w_ovf;
                out_nan  <= w_nan;
                out_udf  <= w_udf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rec_to_fixed_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_rec_to_fixed_pipe
// Description : Self-checking bench for rec_to_fixed_pipe. Two instances run
//               in lockstep (round-to-nearest and truncate). Expected results
//               come from a real-arithmetic model of the conversion or from a
//               table of hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rec_to_fixed_pipe;

    typedef struct packed {
        logic signed [24:0] data;
        logic               ovf;
        logic               nan;
        logic               udf;
    } res_t;

    typedef struct {
        res_t r;
        res_t t;
        int   cyc;
    } sb_t;

    typedef struct {
        logic [32:0] word;
        int          r_data;
        int          t_data;
        bit          ovf;
        bit          nan;
        bit          udf;
    } dir_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [32:0] in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [24:0] out_data;
    logic        out_ovf;
    logic        out_nan;
    logic        out_udf;

    logic        t_in_ready;
    logic        t_out_valid;
    logic [24:0] t_out_data;
    logic        t_out_ovf;
    logic        t_out_nan;
    logic        t_out_udf;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;
    bit  lat_chk  = 0;
    bit  use_ovr  = 0;
    res_t ovr_r;
    res_t ovr_t;
    sb_t q[$];

    rec_to_fixed_pipe #(.ROUND(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_nan   (out_nan),
        .out_udf   (out_udf)
    );

    rec_to_fixed_pipe #(.ROUND(0)) dut_t (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (t_in_ready),
        .in_data   (in_data),
        .out_valid (t_out_valid),
        .out_ready (out_ready),
        .out_data  (t_out_data),
        .out_ovf   (t_out_ovf),
        .out_nan   (t_out_nan),
        .out_udf   (t_out_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Conversion reference: value * 2^16 in real arithmetic, then round.
    function automatic res_t ref_model(input logic [32:0] w, input bit rnd);
        res_t o;
        real  p, x, m, lim;
        int   e, mi;
        o = '0;
        case (w[31:29])
            3'b000: o = '0;
            3'b110: begin
                o.ovf  = 1'b1;
                o.data = w[32] ? -25'sd16777216 : 25'sd16777215;
            end
            3'b111: o.nan = 1'b1;
            default: begin
                e = int'(w[31:23]) - 256 + 16;
                p = 1.0;
                if (e >= 0) repeat (e) p = p * 2.0;
                else repeat (-e) p = p * 0.5;
                x = (1.0 + real'(w[22:0]) / 8388608.0) * p;
                m = rnd ? $floor(x + 0.5) : $floor(x);
                lim = w[32] ? 16777216.0 : 16777215.0;
                if (m > lim) begin
                    o.ovf  = 1'b1;
                    o.data = w[32] ? -25'sd16777216 : 25'sd16777215;
                end else begin
                    mi     = $rtoi(m);
                    o.data = 25'(w[32] ? -mi : mi);
                    o.udf  = (mi == 0);
                end
            end
        endcase
        return o;
    endfunction

    function automatic logic [32:0] rand_word();
        logic [8:0] e;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            case ($urandom_range(0, 2))
                0:       e = {3'b000, 6'($urandom)};
                1:       e = {3'b110, 6'($urandom)};
                default: e = {3'b111, 6'($urandom)};
            endcase
        end else if (r <= 2) begin
            e = 9'($urandom);
        end else begin
            e = 9'(224 + $urandom_range(0, 44));
        end
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // One clock cycle: drive on the falling edge, observe 1 ns later.
    task automatic step(input bit rn, input bit v, input logic [32:0] d,
                        input bit ordy, output bit acc);
        sb_t e;
        @(negedge clk);
        rst_n     = rn;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        cyc++;
        acc = 1'b0;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check_val("spurious_out", 1, 0);
                end else begin
                    e = q[0];
                    check_val("r_data", longint'($signed(out_data)), longint'(e.r.data));
                    check_val("r_ovf", out_ovf, e.r.ovf);
                    check_val("r_nan", out_nan, e.r.nan);
                    check_val("r_udf", out_udf, e.r.udf);
                    check_val("t_valid", t_out_valid, 1);
                    check_val("t_data", longint'($signed(t_out_data)), longint'(e.t.data));
                    check_val("t_ovf", t_out_ovf, e.t.ovf);
                    check_val("t_nan", t_out_nan, e.t.nan);
                    check_val("t_udf", t_out_udf, e.t.udf);
                    if (out_ready) begin
                        if (lat_chk) check_val("latency", cyc - e.cyc, 3);
                        void'(q.pop_front());
                    end
                end
            end else if (t_out_valid) begin
                check_val("t_valid", 1, 0);
            end
            if (in_valid && in_ready) begin
                acc   = 1'b1;
                e.cyc = cyc;
                if (use_ovr) begin
                    e.r = ovr_r;
                    e.t = ovr_t;
                end else begin
                    e.r = ref_model(in_data, 1'b1);
                    e.t = ref_model(in_data, 1'b0);
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic drain(input bit use_pat);
        bit acc;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            step(1'b1, 1'b0, '0, use_pat ? pat[cyc % 4] : 1'b1, acc);
        end
        check_val("drain_left", q.size(), 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_valid"}, out_valid, 0);
        check_val({tag, "_data"}, out_data, 0);
        check_val({tag, "_flags"}, {out_ovf, out_nan, out_udf}, 0);
    endtask

    dir_t dir [11];
    bit   acc;
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   n_acc;
    bit   done;

    initial begin
        dir[0]  = '{{1'b0, 9'h100, 23'h400000},    98304,    98304, 0, 0, 0}; //  1.5
        dir[1]  = '{{1'b1, 9'h102, 23'h100000},  -294912,  -294912, 0, 0, 0}; // -4.5
        dir[2]  = '{{1'b0, 9'h180, 23'h000000}, 16777215, 16777215, 1, 0, 0}; //  inf
        dir[3]  = '{{1'b1, 9'h180, 23'h000000}, -16777216, -16777216, 1, 0, 0}; // -inf
        dir[4]  = '{{1'b0, 9'h108, 23'h160000}, 16777215, 16777215, 1, 0, 0}; //  300.0
        dir[5]  = '{{1'b1, 9'h108, 23'h000000}, -16777216, -16777216, 0, 0, 0}; // -256.0
        dir[6]  = '{{1'b0, 9'h1C0, 23'h400000},        0,        0, 0, 1, 0}; //  nan
        dir[7]  = '{{1'b0, 9'h000, 23'h000000},        0,        0, 0, 0, 0}; //  +0
        dir[8]  = '{{1'b0, 9'h0EC, 23'h0637BD},        0,        0, 0, 0, 1}; //  ~1e-6
        dir[9]  = '{{1'b0, 9'h0F0, 23'h400000},        2,        1, 0, 0, 0}; //  1.5*2^-16
        dir[10] = '{{1'b1, 9'h0F0, 23'h400000},       -2,       -1, 0, 0, 0}; // -1.5*2^-16

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset and first post-reset cycle
        repeat (3) step(1'b0, 1'b0, '0, 1'b0, acc);
        check_val("rst_in_ready", in_ready, 0);
        step(1'b1, 1'b0, '0, 1'b1, acc);
        check_idle_zero("post_rst");
        check_val("post_rst_in_ready", in_ready, 1);

        // Directed table, back-to-back, no stall
        lat_chk = 1'b1;
        use_ovr = 1'b1;
        foreach (dir[i]) begin
            ovr_r = '{25'(dir[i].r_data), dir[i].ovf, dir[i].nan, dir[i].udf};
            ovr_t = '{25'(dir[i].t_data), dir[i].ovf, dir[i].nan, dir[i].udf};
            step(1'b1, 1'b1, dir[i].word, 1'b1, acc);
            check_val("dir_accept", acc, 1);
        end
        use_ovr = 1'b0;
        drain(1'b0);

        // Full stall: exactly three samples fit, then in_ready drops
        lat_chk = 1'b0;
        n_acc   = 0;
        repeat (5) begin
            step(1'b1, 1'b1, rand_word(), 1'b0, acc);
            if (acc) n_acc++;
        end
        check_val("fill_count", n_acc, 3);
        check_val("fill_in_ready", in_ready, 0);
        check_val("fill_t_in_ready", t_in_ready, 0);
        drain(1'b0);

        // Ten samples streamed while out_ready cycles 1,0,0,1
        for (int i = 0; i < 10; i++) begin
            logic [32:0] w;
            w    = rand_word();
            done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                step(1'b1, 1'b1, w, pat[cyc % 4], acc);
                done = acc;
            end
            if (!done) check_val("bp_accept_timeout", 0, 1);
        end
        drain(1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step(1'b1, ($urandom_range(0, 9) < 7), rand_word(),
                 ($urandom_range(0, 9) < 7), acc);
        end
        drain(1'b0);

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rand_word(), 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b0, acc);
        check_val("mid_rst_in_ready", in_ready, 0);
        step(1'b1, 1'b0, '0, 1'b1, acc);
        check_idle_zero("mid_rst");
        lat_chk = 1'b1;
        step(1'b1, 1'b1, {1'b1, 9'h102, 23'h100000}, 1'b1, acc);
        check_val("fresh_accept", acc, 1);
        drain(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rec_to_fixed_pipe.md
Name: rec_to_fixed_pipe

Overview:
- Pipelined, parametrised converter from HardFloat-recoded floating point (recFN) to signed fixed point.
- Gives the float representation its bridge into fixed-point consumers such as DACs, LUT indices and fixed datapaths.
- Handles zero, tiny, huge, inf and nan explicitly and reports per-sample status flags.
- Uses a three-stage valid/ready pipeline with bubble collapsing and full backpressure.

Parameters:
- EXP_BITS, 8, IEEE exponent width; the recoded exponent field is EXP_BITS+1 bits.
- SIG_BITS, 24, significand width including the hidden bit; recoded width is REC_W = EXP_BITS+SIG_BITS+1.
- FIX_WIDTH, 25, width of the signed two's-complement output.
- FIX_EXP, -16, fixed-point exponent; the real value equals out_data * 2^FIX_EXP.
- ROUND, 1, rounding mode: 0 truncates toward zero, 1 rounds to nearest with ties away from zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  converter can accept a sample this cycle.
- in_data  in  REC_W  recFN word: sign [REC_W-1], exponent [REC_W-2:SIG_BITS-1], fraction [SIG_BITS-2:0].
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  FIX_WIDTH  converted value.
- out_ovf  out  1  output was saturated (finite overflow or inf).
- out_nan  out  1  input was nan; out_data is 0.
- out_udf  out  1  nonzero finite input produced out_data == 0.

Behaviour:
- Classification uses the top 3 exponent bits: 000 zero, 110 inf, 111 nan, anything else finite nonzero.
- For finite nonzero inputs, value = (-1)^s * 2^E * 1.frac with E = expField - 2^EXP_BITS. Subnormals are already normalised by the recoding.
- Stage 1 (decode): register the class, sign, E and the integer significand M = {1, frac}.
- Stage 2 (align): shift amount S = E - (SIG_BITS-1) - FIX_EXP.
  - S >= FIX_WIDTH: set the definite-overflow bit.
  - S < -(SIG_BITS+1): magnitude becomes 0, guard 0, sticky 1.
  - Otherwise shift M into a FIX_WIDTH+1-bit magnitude and keep guard and sticky bits.
- Stage 3 (round/saturate):
  - ROUND=1: add the guard bit to the magnitude. ROUND=0: ignore guard and sticky.
  - Saturation limits are +(2^(FIX_WIDTH-1)-1) and -2^(FIX_WIDTH-1); a negative magnitude of exactly 2^(FIX_WIDTH-1) is not an overflow.
  - inf: out_data = ±limit, out_ovf=1.
  - nan: out_data=0, out_nan=1, other flags 0.
  - Zero: out_data=0, all flags 0.
  - out_udf=1 only for finite nonzero inputs whose rounded result is 0.
- Latency: 3 cycles from input handshake to out_valid when no stall. Throughput: 1 sample per cycle.
- Handshake:
  - Each stage holds a valid bit and loads when it is empty or its contents are moving forward this cycle.
  - in_ready = !v1 || stage 2 can load; the path is combinational back from out_ready.
  - out_valid = v3. out_data and flags stay stable while out_valid && !out_ready.
  - Bubbles collapse: one empty stage lets upstream advance even while the output is stalled.
- Simultaneous accept and emit in the same cycle is allowed with full pipeline occupancy.
- Reset (rst_n=0 at a clock edge, including mid-stream): clear all valid bits and drop in-flight samples.
  - out_valid=0, out_data=0, all flags=0.
  - in_ready=0 during reset and 1 on the first cycle after reset.
- Data registers of invalid stages may hold any value but must not be X on outputs after reset.

Decomposition:
- Package svreal_rec_pkg holds:
  - rec_class_t enum (REC_ZERO, REC_FINITE, REC_INF, REC_NAN);
  - localparam function rec_width(exp, sig);
  - the class-decode bit patterns 3'b000, 3'b110, 3'b111.
- One sub-module, rec_fn_classify: combinational, recFN word in; class, sign, E and M out. It is reused by future recFN blocks.

Test Plan (EXP_BITS=8, SIG_BITS=24, FIX_WIDTH=25, FIX_EXP=-16):
- 1.5 (expField 9'h100, frac 23'h400000), out_ready=1 -> out_data=98304 after 3 cycles, flags 0. -4.5 -> -294912.
- Saturation: inf -> 16777215 with ovf=1; -inf -> -16777216 with ovf=1; 300.0 -> 16777215 with ovf=1; -256.0 -> -16777216 with ovf=0.
- Specials: nan -> 0 with nan=1; +0 -> 0 with all flags 0.
- Tiny values: 1e-6 -> 0 with udf=1. ROUND=1 vs ROUND=0 on 1.5*2^-16 -> 2 vs 1; on -1.5*2^-16 -> -2 vs -1.
- Backpressure:
  - Stream 10 back-to-back samples while out_ready toggles 1,0,0,1.
  - All 10 must come out in order with no loss or duplication.
  - Outputs must hold stable while stalled, and in_ready must drop after 3 held samples.
- Reset: assert rst_n=0 for 1 cycle with 3 samples in flight -> next cycle out_valid=0 and outputs 0; a fresh sample then emerges 3 cycles after acceptance.
